// File: rtl/adc_sample_packer_pkg.sv
// Shared constants and state encoding for the ADC sample packer and its output buffer.
// The flush marker marks the unused upper half of a partial word at the end of a window.
package adc_sample_packer_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int HALF_WIDTH = 16;

    // Cannot collide with a real sample because ADC_WIDTH never exceeds 15 bits.
    localparam logic [HALF_WIDTH-1:0] FLUSH_MARKER = 16'h8000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b01,
        ST_HALF  = 2'b10
    } pack_state_t;

endpackage

// File: rtl/adc_sample_packer_out_word_buffer.sv
// Single-entry holding register between the packer and the capture FIFO.
// Produces the FIFO write request, and write/drop pulses for the status counters.
module adc_sample_packer_out_word_buffer
    import adc_sample_packer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WRREQ,
    output logic [WORD_WIDTH-1:0] FIFO_DATA,
    output logic                  out_valid,
    output logic                  write_pulse,
    output logic                  drop_pulse
);

    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic [WORD_WIDTH-1:0] data_reg;
    logic [WORD_WIDTH-1:0] data_next;
    logic                  wrreq;
    logic                  drop;

    always_comb begin
        wrreq          = out_valid_reg & ~FIFO_FULL;
        drop           = word_ready & out_valid_reg & FIFO_FULL;
        out_valid_next = out_valid_reg;
        data_next      = data_reg;
        if (word_ready) begin
            // A new word replaces the buffered one whenever the buffer is empty or
            // being written this edge; only a full FIFO with a held word drops it.
            if (!drop) begin
                data_next      = word_data;
                out_valid_next = 1'b1;
            end
        end else if (wrreq) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            data_reg      <= data_next;
        end
    end

    assign FIFO_WRREQ  = wrreq;
    assign FIFO_DATA   = data_reg;
    assign out_valid   = out_valid_reg;
    assign write_pulse = wrreq;
    assign drop_pulse  = drop;

endmodule

// File: rtl/adc_sample_packer.sv
// Packs pairs of ADC samples into 32-bit words for the capture FIFO, flushing odd
// windows with a marker half-word, and keeps saturating word/drop counters for software.
module adc_sample_packer
    import adc_sample_packer_pkg::*;
#(
    parameter int ADC_WIDTH   = 12,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [ADC_WIDTH-1:0]   ADC_DATA,
    input  logic                   SAMPLE_EN,
    input  logic                   CLR_STATUS,
    input  logic                   FIFO_FULL,
    output logic                   FIFO_WRREQ,
    output logic [WORD_WIDTH-1:0]  FIFO_DATA,
    output logic [COUNT_WIDTH-1:0] WORD_COUNT,
    output logic [COUNT_WIDTH-1:0] DROP_COUNT,
    output logic                   OVERFLOW,
    output logic                   PACK_IDLE
);

    pack_state_t           state_reg;
    pack_state_t           state_next;
    logic [HALF_WIDTH-1:0] low_half_reg;
    logic [HALF_WIDTH-1:0] low_half_next;
    logic [HALF_WIDTH-1:0] sample_ext;
    logic                  word_ready;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  out_valid;
    logic                  write_pulse;
    logic                  drop_pulse;
    logic                  overflow_reg;

    assign sample_ext = {{(HALF_WIDTH-ADC_WIDTH){1'b0}}, ADC_DATA};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= ST_EMPTY;
            low_half_reg <= '0;
        end else begin
            state_reg    <= state_next;
            low_half_reg <= low_half_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        low_half_next = low_half_reg;
        word_ready    = 1'b0;
        word_data     = '0;
        case (state_reg)
            ST_EMPTY: begin
                if (SAMPLE_EN) begin
                    low_half_next = sample_ext;
                    state_next    = ST_HALF;
                end
            end
            ST_HALF: begin
                // Either the pair completes or the window closed on an odd sample.
                word_ready = 1'b1;
                state_next = ST_EMPTY;
                if (SAMPLE_EN) begin
                    word_data = {sample_ext, low_half_reg};
                end else begin
                    word_data = {FLUSH_MARKER, low_half_reg};
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    adc_sample_packer_out_word_buffer u_out_word_buffer (
        .CLK         (CLK),
        .RESET       (RESET),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .FIFO_FULL   (FIFO_FULL),
        .FIFO_WRREQ  (FIFO_WRREQ),
        .FIFO_DATA   (FIFO_DATA),
        .out_valid   (out_valid),
        .write_pulse (write_pulse),
        .drop_pulse  (drop_pulse)
    );

    // Index 0 counts FIFO writes, index 1 counts dropped words.
    logic [1:0]                  cnt_inc;
    logic [1:0][COUNT_WIDTH-1:0] cnt_value;

    assign cnt_inc = {drop_pulse, write_pulse};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [COUNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    cnt_reg <= '0;
                end else if (CLR_STATUS) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_value[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            overflow_reg <= 1'b0;
        end else if (CLR_STATUS) begin
            overflow_reg <= 1'b0;
        end else if (drop_pulse) begin
            overflow_reg <= 1'b1;
        end
    end

    assign WORD_COUNT = cnt_value[0];
    assign DROP_COUNT = cnt_value[1];
    assign OVERFLOW   = overflow_reg;
    assign PACK_IDLE  = (state_reg == ST_EMPTY) && !out_valid;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer: per-cycle vector table plus hand sequences for
// counter saturation, clear priority and mid-window reset (narrow-counter second instance).
module tb_adc_sample_packer;

    logic        CLK;
    logic        RESET;
    logic [11:0] ADC_DATA;
    logic        SAMPLE_EN;
    logic        CLR_STATUS;
    logic        FIFO_FULL;

    logic        wrreq0;
    logic [31:0] data0;
    logic [15:0] wc0;
    logic [15:0] dc0;
    logic        ovf0;
    logic        idle0;

    logic        wrreq1;
    logic [31:0] data1;
    logic [3:0]  wc1;
    logic [3:0]  dc1;
    logic        ovf1;
    logic        idle1;

    int n_cmp  = 0;
    int n_fail = 0;

    adc_sample_packer #(.ADC_WIDTH(12), .COUNT_WIDTH(16)) dut0 (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADC_DATA   (ADC_DATA),
        .SAMPLE_EN  (SAMPLE_EN),
        .CLR_STATUS (CLR_STATUS),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRREQ (wrreq0),
        .FIFO_DATA  (data0),
        .WORD_COUNT (wc0),
        .DROP_COUNT (dc0),
        .OVERFLOW   (ovf0),
        .PACK_IDLE  (idle0)
    );

    adc_sample_packer #(.ADC_WIDTH(12), .COUNT_WIDTH(4)) dut1 (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADC_DATA   (ADC_DATA),
        .SAMPLE_EN  (SAMPLE_EN),
        .CLR_STATUS (CLR_STATUS),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRREQ (wrreq1),
        .FIFO_DATA  (data1),
        .WORD_COUNT (wc1),
        .DROP_COUNT (dc1),
        .OVERFLOW   (ovf1),
        .PACK_IDLE  (idle1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [11:0] adc;
        logic        full;
        logic        clr;
        logic        wrreq;
        logic [31:0] data;
        logic [15:0] wc;
        logic [15:0] dc;
        logic        ovf;
        logic        idle;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [11:0] adc, input logic full,
                                input logic clr, input logic wrreq, input logic [31:0] data,
                                input logic [15:0] wc, input logic [15:0] dc,
                                input logic ovf, input logic idle);
        vec_t v;
        v.en = en; v.adc = adc; v.full = full; v.clr = clr;
        v.wrreq = wrreq; v.data = data; v.wc = wc; v.dc = dc; v.ovf = ovf; v.idle = idle;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [11:0] adc, input logic full, input logic clr);
        SAMPLE_EN  = en;
        ADC_DATA   = adc;
        FIFO_FULL  = full;
        CLR_STATUS = clr;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        RESET = 1'b1;
        #1;
        check("reset_wrreq", {31'd0, wrreq0}, 32'd0);
        check("reset_data", data0, 32'd0);
        check("reset_wc", {16'd0, wc0}, 32'd0);
        check("reset_dc", {16'd0, dc0}, 32'd0);
        check("reset_ovf", {31'd0, ovf0}, 32'd0);
        check("reset_idle", {31'd0, idle0}, 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        next_cycle();

        // Test 1: four samples, FIFO never full.
        vecs.push_back(mk(1, 12'h001, 0, 0, 0, 32'h00000000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h002, 0, 0, 0, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h003, 0, 0, 1, 32'h00020001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h004, 0, 0, 0, 32'h00020001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 32'h00040003, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 32'h00040003, 2, 0, 0, 1));
        // Test 2: odd window, flush word with marker.
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 32'h00040003, 2, 0, 0, 1));
        vecs.push_back(mk(1, 12'h123, 0, 0, 0, 32'h00040003, 2, 0, 0, 0));
        vecs.push_back(mk(1, 12'hFFF, 0, 0, 1, 32'h01230ABC, 2, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 32'h01230ABC, 3, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 32'h80000FFF, 3, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 32'h80000FFF, 4, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1, 0, 32'h80000FFF, 4, 0, 0, 1));
        // Test 3: FIFO full for an 8-sample window, then released.
        vecs.push_back(mk(1, 12'h001, 1, 0, 0, 32'h80000FFF, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h002, 1, 0, 0, 32'h80000FFF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h003, 1, 0, 0, 32'h00020001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h004, 1, 0, 0, 32'h00020001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h005, 1, 0, 0, 32'h00020001, 0, 1, 1, 0));
        vecs.push_back(mk(1, 12'h006, 1, 0, 0, 32'h00020001, 0, 1, 1, 0));
        vecs.push_back(mk(1, 12'h007, 1, 0, 0, 32'h00020001, 0, 2, 1, 0));
        vecs.push_back(mk(1, 12'h008, 1, 0, 0, 32'h00020001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 32'h00020001, 0, 3, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 32'h00020001, 0, 3, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 32'h00020001, 1, 3, 1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1, 0, 32'h00020001, 1, 3, 1, 1));
        // Test 4: one-cycle FULL pulse while the buffer is empty and word 2 is ready.
        vecs.push_back(mk(1, 12'h011, 0, 0, 0, 32'h00020001, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h022, 0, 0, 0, 32'h00020001, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h033, 0, 0, 1, 32'h00220011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h044, 1, 0, 0, 32'h00220011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 32'h00440033, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 32'h00440033, 2, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].adc, vecs[i].full, vecs[i].clr);
            @(negedge CLK);
            $display("vec %0d: en=%0d adc=%03h full=%0d clr=%0d -> wrreq=%0d data=%08h wc=%0d dc=%0d ovf=%0d idle=%0d",
                     i, vecs[i].en, vecs[i].adc, vecs[i].full, vecs[i].clr,
                     wrreq0, data0, wc0, dc0, ovf0, idle0);
            check($sformatf("v%0d_wrreq", i), {31'd0, wrreq0}, {31'd0, vecs[i].wrreq});
            check($sformatf("v%0d_data", i), data0, vecs[i].data);
            check($sformatf("v%0d_wc", i), {16'd0, wc0}, {16'd0, vecs[i].wc});
            check($sformatf("v%0d_dc", i), {16'd0, dc0}, {16'd0, vecs[i].dc});
            check($sformatf("v%0d_ovf", i), {31'd0, ovf0}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_idle", i), {31'd0, idle0}, {31'd0, vecs[i].idle});
            next_cycle();
        end

        // Test 5: 40 samples -> 20 words; 4-bit counter saturates at 15.
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        RESET = 1'b1;
        #1;
        @(negedge CLK);
        RESET = 1'b0;
        next_cycle();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 12'(i + 1), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) next_cycle();
        $display("sat: wc16=%0d wc4=%0d data=%08h", wc0, wc1, data0);
        check("sat_wc4", {28'd0, wc1}, 32'd15);
        check("sat_wc16", {16'd0, wc0}, 32'd20);
        check("sat_last_word", data0, 32'h00280027);
        check("sat_dc4", {28'd0, dc1}, 32'd0);
        check("sat_ovf4", {31'd0, ovf1}, 32'd0);
        check("sat_idle4", {31'd0, idle1}, 32'd1);

        // CLR_STATUS coincident with a write wins.
        drive(1'b1, 12'h005, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 12'h006, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        @(negedge CLK);
        $display("clr: wrreq=%0d data=%08h wc4=%0d", wrreq1, data1, wc1);
        check("clr_wrreq", {31'd0, wrreq1}, 32'd1);
        check("clr_data", data1, 32'h00060005);
        next_cycle();
        CLR_STATUS = 1'b0;
        @(negedge CLK);
        $display("post-clr: wc4=%0d wc16=%0d", wc1, wc0);
        check("clr_wc4", {28'd0, wc1}, 32'd0);
        check("clr_wc16", {16'd0, wc0}, 32'd0);
        next_cycle();

        // Test 6: reset while in HALF with a buffered word (plus a drop recorded).
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 12'(i + 1), 1'b1, 1'b0);
            next_cycle();
        end
        $display("pre-reset: idle=%0d dc=%0d ovf=%0d data=%08h", idle0, dc0, ovf0, data0);
        check("prerst_idle", {31'd0, idle0}, 32'd0);
        check("prerst_dc", {16'd0, dc0}, 32'd1);
        check("prerst_ovf", {31'd0, ovf0}, 32'd1);
        check("prerst_data", data0, 32'h00020001);
        #2;
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        RESET = 1'b1;
        #1;
        $display("mid-reset: wrreq=%0d data=%08h dc=%0d ovf=%0d idle=%0d", wrreq0, data0, dc0, ovf0, idle0);
        check("rst_wrreq", {31'd0, wrreq0}, 32'd0);
        check("rst_data", data0, 32'd0);
        check("rst_dc", {16'd0, dc0}, 32'd0);
        check("rst_ovf", {31'd0, ovf0}, 32'd0);
        check("rst_idle", {31'd0, idle0}, 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            $display("post-reset %0d: wrreq=%0d idle=%0d data=%08h", i, wrreq0, idle0, data0);
            check($sformatf("postrst%0d_wrreq", i), {31'd0, wrreq0}, 32'd0);
            check($sformatf("postrst%0d_idle", i), {31'd0, idle0}, 32'd1);
            check($sformatf("postrst%0d_data", i), data0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Downstream stage of the ultrasound acquisition FSM.
- Takes the per-cycle acquisition enable (the FSM's FIFO_EN) and the raw ADC bus.
- Packs two samples into each 32-bit word and writes the words into the capture FIFO through a one-word holding buffer.
- Flushes partial words at the end of the window, and reports word, drop and overflow status to software.

Parameters:
ADC_WIDTH, 12, ADC sample width in bits; legal range 8..15. Each sample is zero-extended to 16 bits.
COUNT_WIDTH, 16, width of the WORD_COUNT and DROP_COUNT status counters.

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
ADC_DATA  input  ADC_WIDTH  ADC sample, sampled on the CLK edge
SAMPLE_EN  input  1  sample-valid; driven by the FSM's FIFO_EN; one sample per cycle while high
CLR_STATUS  input  1  synchronous clear of WORD_COUNT, DROP_COUNT and OVERFLOW
FIFO_FULL  input  1  capture FIFO full flag
FIFO_WRREQ  output  1  FIFO write request; combinational, equal to out_valid AND NOT FIFO_FULL
FIFO_DATA  output  32  registered holding-buffer word
WORD_COUNT  output  COUNT_WIDTH  words accepted by the FIFO; saturating
DROP_COUNT  output  COUNT_WIDTH  words discarded; saturating
OVERFLOW  output  1  sticky; set on any drop
PACK_IDLE  output  1  high when no half-word is pending and out_valid is 0

Behaviour:
Reset (asynchronous):
- Packer state goes to EMPTY; out_valid=0.
- FIFO_DATA=0, FIFO_WRREQ=0.
- WORD_COUNT=0, DROP_COUNT=0, OVERFLOW=0, PACK_IDLE=1.
- Reset asserted mid-window discards any pending half-word and any buffered word, with no flush.

Word format:
- bits[15:0] = first sample, zero-extended.
- bits[31:16] = second sample, zero-extended.
- Partial (flush) word: bits[31:16] = 16'h8000. This is a marker that cannot occur as a sample because ADC_WIDTH <= 15.

Packer FSM (2 states):
- EMPTY:
  - SAMPLE_EN=1 → latch ADC_DATA into the low half; go to HALF.
- HALF:
  - SAMPLE_EN=1 → complete the word with ADC_DATA as the high half ("word ready"); go to EMPTY.
  - SAMPLE_EN=0 → the window has ended with an odd sample count: form the flush word ("word ready"); go to EMPTY.
- SAMPLE_EN low in EMPTY → no action.
- A window of N samples produces ceil(N/2) words.
- Back-to-back windows need no idle cycle beyond the SAMPLE_EN low gap.

Holding buffer, evaluated at each edge where a word is ready:
- out_valid=0 → load the word; out_valid=1.
- out_valid=1 and FIFO_FULL=0 → the current word is written at this edge (FIFO_WRREQ was high) and the buffer is reloaded with the new word. This is not a drop.
- out_valid=1 and FIFO_FULL=1 → the new word is discarded. DROP_COUNT increments, OVERFLOW is set, and the buffered word is retained.

Holding buffer, edge with no word ready:
- out_valid clears if FIFO_WRREQ is high; otherwise the buffer holds.

Latency:
- The second sample is accepted at edge t.
- FIFO_DATA is valid and FIFO_WRREQ is high during cycle t+1, provided FIFO_FULL=0.

Counters:
- WORD_COUNT increments on each cycle with FIFO_WRREQ=1.
- Both counters saturate at all-ones.
- CLR_STATUS takes priority over a coincident increment or OVERFLOW set; the result is 0.
- CLR_STATUS does not affect packing or the buffer.

PACK_IDLE:
- Software reads DONE from the FSM and PACK_IDLE together before draining the FIFO.
- PACK_IDLE goes high one cycle after the last word is accepted by the FIFO.

Decomposition:
- Shared package holds:
  - the flush-marker constant (16'h8000);
  - the packer state encoding (EMPTY, HALF; one-hot, consistent with the FSM style);
  - the 32-bit word width constant.
- One sub-module is natural: out_word_buffer. It contains the single-entry holding register, the WRREQ/full logic and the drop detect, and exports drop and write pulses to the counters in the top level.

Test Plan:
1. Window of 4 samples (0x001, 0x002, 0x003, 0x004), FIFO_FULL=0 → two writes, 0x00020001 then 0x00040003. Each FIFO_WRREQ occurs one cycle after its second sample. WORD_COUNT=2, PACK_IDLE=1 afterwards.
2. Window of 3 samples (0xABC, 0x123, 0xFFF) → words 0x01230ABC and 0x80000FFF. The flush word's FIFO_WRREQ comes 2 cycles after SAMPLE_EN falls.
3. FIFO_FULL=1 throughout an 8-sample window → first word held; words 2..4 dropped. DROP_COUNT=3, OVERFLOW=1. FIFO_FULL released → one write of 0x00020001, WORD_COUNT=1.
4. FIFO_FULL pulses high for 1 cycle coincident with the second word being ready → no drop; both words written in order; DROP_COUNT=0.
5. Saturation and clear: COUNT_WIDTH=4, 40 samples, FIFO_FULL=0 → WORD_COUNT reaches 15 and stays there. CLR_STATUS asserted in the same cycle as a write → WORD_COUNT reads 0 on the next cycle.
6. RESET asserted while in HALF with out_valid=1 → all outputs return to reset values immediately. No flush word appears after RESET deasserts.
